// File: rtl/ahbl_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_stream_writer_if
// Description : Bundles the valid/ready word stream and the AHB-Lite master
//               signals used by ahbl_stream_writer. The master modport is the
//               writer's view; the slave modport is the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahbl_stream_writer_if #(
    parameter int AHB_AWIDTH = 20
);
    // Stream side
    logic                  s_valid;
    logic [31:0]           s_data;
    logic                  s_ready;

    // AHB-Lite side
    logic [AHB_AWIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    modport master (
        input  s_valid, s_data, HREADY, HRESP,
        output s_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output s_valid, s_data, HREADY, HRESP,
        input  s_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahbl_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_stream_writer
// Description : AHB-Lite write master. Drains a valid/ready stream of 32-bit
//               words into LEN consecutive word addresses starting at a
//               programmed base, with pipelined SINGLE/NONSEQ transfers.
//               Reports completion via done and ERROR responses via err.
// Option      : AHBL_STREAM_WRITER_WAITCNT_EN - enables the wait-state counter
//               on wait_cnt; otherwise wait_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_stream_writer #(
    parameter int AHB_AWIDTH = 20,
    parameter int LEN_WIDTH  = 16
) (
    input  wire logic                  HCLK,
    input  wire logic                  HRESET,
    input  wire logic                  start,
    input  wire logic [AHB_AWIDTH-1:0] base,
    input  wire logic [LEN_WIDTH-1:0]  len,
    ahbl_stream_writer_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [AHB_AWIDTH-1:0]      err_addr,
    output logic [15:0]                wait_cnt
);

    localparam logic [1:0] c_trans_idle   = 2'b00;
    localparam logic [1:0] c_trans_nonseq = 2'b10;
    localparam logic [1:0] c_resp_error   = 2'b01;
    localparam logic [2:0] c_size_word    = 3'b010;
    localparam logic [2:0] c_burst_single = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [AHB_AWIDTH-1:0] addr_q,     addr_d;
    logic [LEN_WIDTH-1:0]  rem_q,      rem_d;
    logic                  dphase_q,   dphase_d;
    logic [AHB_AWIDTH-1:0] dph_addr_q, dph_addr_d;
    logic [31:0]           hwdata_q,   hwdata_d;
    logic                  err_q,      err_d;
    logic [AHB_AWIDTH-1:0] err_addr_q, err_addr_d;

    logic w_err_active;
    logic w_issue;
    logic w_accept;
    logic w_start_ok;

    // Address-phase decode: an ERROR on the outstanding data phase suppresses
    // any new transfer in the same cycle, before HREADY rises.
    always_comb begin
        w_err_active = dphase_q && (bus.HRESP == c_resp_error);
        w_issue      = (state_q == ST_RUN) && bus.s_valid &&
                       (rem_q != '0) && !w_err_active;
        w_accept     = w_issue && bus.HREADY;
        w_start_ok   = (state_q == ST_IDLE) && start;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        dphase_d   = dphase_q;
        dph_addr_d = dph_addr_q;
        hwdata_d   = hwdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        // Data pipeline: a new accept opens a data phase, otherwise HREADY
        // retires the outstanding one.
        if (w_accept) begin
            hwdata_d   = bus.s_data;
            dphase_d   = 1'b1;
            dph_addr_d = addr_q;
            addr_d     = addr_q + AHB_AWIDTH'(4);
            rem_d      = rem_q - LEN_WIDTH'(1);
        end else if (bus.HREADY) begin
            dphase_d = 1'b0;
        end

        if (w_err_active) begin
            err_addr_d = dph_addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    addr_d  = base & ~AHB_AWIDTH'(3);
                    rem_d   = len;
                    err_d   = 1'b0;
                    state_d = (len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_err_active && bus.HREADY) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (w_accept && (rem_q == LEN_WIDTH'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_err_active && bus.HREADY) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (dphase_q && bus.HREADY) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                dphase_d = 1'b0;
                state_d  = ST_IDLE;
            end
            ST_ERR: begin
                dphase_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                dphase_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            dphase_q   <= 1'b0;
            dph_addr_q <= '0;
            hwdata_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            dphase_q   <= dphase_d;
            dph_addr_q <= dph_addr_d;
            hwdata_q   <= hwdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Bus and status outputs
    always_comb begin
        bus.HTRANS  = w_issue ? c_trans_nonseq : c_trans_idle;
        bus.HADDR   = addr_q;
        bus.HWDATA  = hwdata_q;
        bus.HWRITE  = 1'b1;
        bus.HSIZE   = c_size_word;
        bus.HBURST  = c_burst_single;
        bus.s_ready = w_accept;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FIN) || (state_q == ST_ERR);
        err         = err_q;
        err_addr    = err_addr_q;
    end

`ifdef AHBL_STREAM_WRITER_WAITCNT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Saturating count of stalled data-phase cycles for the current operation
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (w_start_ok) begin
            wait_cnt_d = '0;
        end else if (dphase_q && !bus.HREADY && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Wait-state counter register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`else
    assign wait_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahbl_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_stream_writer
// Description : Directed self-checking bench for ahbl_stream_writer. Inputs
//               change on the falling edge; outputs are checked 1 time unit
//               later, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_stream_writer;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [19:0] base;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [19:0] err_addr;
    logic [15:0] wait_cnt;

    int total    = 0;
    int passed   = 0;
    int accepted = 0;
    int acc0;

    logic [31:0] w [0:3];
    logic [15:0] exp_wait;

    ahbl_stream_writer_if #(.AHB_AWIDTH(20)) bus ();

    ahbl_stream_writer #(
        .AHB_AWIDTH (20),
        .LEN_WIDTH  (16)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .start    (start),
        .base     (base),
        .len      (len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr),
        .wait_cnt (wait_cnt)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (bus.s_ready === 1'b1) accepted <= accepted + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        w[0] = 32'hA5A5_0001; w[1] = 32'h5A5A_0002;
        w[2] = 32'hDEAD_0003; w[3] = 32'hBEEF_0004;
`ifdef AHBL_STREAM_WRITER_WAITCNT_EN
        exp_wait = 16'd3;
`else
        exp_wait = 16'd0;
`endif
        HRESET = 1'b1; start = 1'b0; base = '0; len = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        // Reset state
        chk("rst_htrans", bus.HTRANS, 2'b00);
        chk("rst_haddr", bus.HADDR, 20'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, 20'h0);
        chk("rst_wait_cnt", wait_cnt, 16'h0);
        chk("const_hwrite", bus.HWRITE, 1'b1);
        chk("const_hsize", bus.HSIZE, 3'b010);
        chk("const_hburst", bus.HBURST, 3'b000);

        // Basic 4-word transfer, no stalls
        @(negedge HCLK);
        start = 1'b1; base = 20'h00100; len = 16'd4;
        bus.s_valid = 1'b1; bus.s_data = w[0];
        #1 chk("t1_idle_htrans", bus.HTRANS, 2'b00);
        @(negedge HCLK); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_htrans", bus.HTRANS, 2'b10);
            chk("t1_haddr", bus.HADDR, 32'h100 + 32'(4 * i));
            chk("t1_s_ready", bus.s_ready, 1'b1);
            if (i > 0) chk("t1_hwdata", bus.HWDATA, w[i-1]);
            @(negedge HCLK);
            if (i < 3) bus.s_data = w[i+1];
            else       bus.s_valid = 1'b0;
        end
        #1;
        chk("t1_last_htrans", bus.HTRANS, 2'b00);
        chk("t1_last_hwdata", bus.HWDATA, w[3]);
        chk("t1_done_early", done, 1'b0);
        chk("t1_busy", busy, 1'b1);
        @(negedge HCLK); #1;
        chk("t1_done", done, 1'b1);
        @(negedge HCLK); #1;
        chk("t1_done_after", done, 1'b0);
        chk("t1_busy_after", busy, 1'b0);

        // Wait states on the first data phase
        start = 1'b1; base = 20'h00100; len = 16'd2;
        bus.s_valid = 1'b1; bus.s_data = w[0];
        @(negedge HCLK); start = 1'b0;
        #1;
        chk("t2_haddr0", bus.HADDR, 20'h00100);
        chk("t2_s_ready0", bus.s_ready, 1'b1);
        @(negedge HCLK); bus.s_data = w[1]; bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_htrans", bus.HTRANS, 2'b10);
            chk("t2_stall_haddr", bus.HADDR, 20'h00104);
            chk("t2_stall_hwdata", bus.HWDATA, w[0]);
            chk("t2_stall_s_ready", bus.s_ready, 1'b0);
            @(negedge HCLK);
        end
        bus.HREADY = 1'b1;
        #1;
        chk("t2_release_s_ready", bus.s_ready, 1'b1);
        chk("t2_release_haddr", bus.HADDR, 20'h00104);
        @(negedge HCLK); bus.s_valid = 1'b0;
        #1;
        chk("t2_hwdata1", bus.HWDATA, w[1]);
        chk("t2_done_early", done, 1'b0);
        @(negedge HCLK); #1;
        chk("t2_done", done, 1'b1);
        chk("t2_wait_cnt", wait_cnt, exp_wait);
        @(negedge HCLK); #1;
        chk("t2_busy_after", busy, 1'b0);
        chk("t2_wait_hold", wait_cnt, exp_wait);

        // Stream gap between two words
        start = 1'b1; base = 20'h00300; len = 16'd2;
        bus.s_valid = 1'b1; bus.s_data = w[2];
        @(negedge HCLK); start = 1'b0;
        #1;
        chk("t3_haddr0", bus.HADDR, 20'h00300);
        chk("t3_htrans0", bus.HTRANS, 2'b10);
        @(negedge HCLK); bus.s_valid = 1'b0;
        #1;
        chk("t3_gap_htrans", bus.HTRANS, 2'b00);
        chk("t3_gap_s_ready", bus.s_ready, 1'b0);
        chk("t3_gap_busy", busy, 1'b1);
        @(negedge HCLK); bus.s_valid = 1'b1; bus.s_data = w[3];
        #1;
        chk("t3_haddr1", bus.HADDR, 20'h00304);
        chk("t3_htrans1", bus.HTRANS, 2'b10);
        chk("t3_hwdata0", bus.HWDATA, w[2]);
        @(negedge HCLK); bus.s_valid = 1'b0;
        #1;
        chk("t3_hwdata1", bus.HWDATA, w[3]);
        chk("t3_done_early", done, 1'b0);
        @(negedge HCLK); #1;
        chk("t3_done", done, 1'b1);
        @(negedge HCLK); #1;
        chk("t3_done_once", done, 1'b0);

        // ERROR on the second data phase
        acc0 = accepted;
        start = 1'b1; base = 20'h00100; len = 16'd4;
        bus.s_valid = 1'b1; bus.s_data = w[0];
        @(negedge HCLK); start = 1'b0;
        #1 chk("t4_haddr0", bus.HADDR, 20'h00100);
        @(negedge HCLK); bus.s_data = w[1];
        #1;
        chk("t4_haddr1", bus.HADDR, 20'h00104);
        chk("t4_s_ready1", bus.s_ready, 1'b1);
        @(negedge HCLK); bus.s_data = w[2]; bus.HRESP = 2'b01; bus.HREADY = 1'b0;
        #1;
        chk("t4_err1_htrans", bus.HTRANS, 2'b00);
        chk("t4_err1_s_ready", bus.s_ready, 1'b0);
        chk("t4_err1_done", done, 1'b0);
        @(negedge HCLK); bus.HREADY = 1'b1;
        #1;
        chk("t4_err2_htrans", bus.HTRANS, 2'b00);
        chk("t4_err2_s_ready", bus.s_ready, 1'b0);
        chk("t4_err_addr", err_addr, 20'h00104);
        @(negedge HCLK); bus.HRESP = 2'b00; bus.s_valid = 1'b0;
        #1;
        chk("t4_done", done, 1'b1);
        chk("t4_err", err, 1'b1);
        @(negedge HCLK); #1;
        chk("t4_done_after", done, 1'b0);
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_err_sticky", err, 1'b1);
        chk("t4_consumed", 32'(accepted - acc0), 32'd2);

        // len=0, plus a start coinciding with done
        start = 1'b1; base = 20'h00200; len = 16'd0;
        @(negedge HCLK);
        start = 1'b1; base = 20'h00500; len = 16'd1;
        #1;
        chk("t5_done", done, 1'b1);
        chk("t5_htrans", bus.HTRANS, 2'b00);
        chk("t5_err_cleared", err, 1'b0);
        @(negedge HCLK); start = 1'b0;
        #1;
        chk("t5_start_on_done_ignored", busy, 1'b0);
        chk("t5_done_after", done, 1'b0);

        // Address wrap at the top of the space
        start = 1'b1; base = 20'hFFFFC; len = 16'd2;
        bus.s_valid = 1'b1; bus.s_data = w[0];
        @(negedge HCLK); start = 1'b0;
        #1 chk("t6_haddr0", bus.HADDR, 20'hFFFFC);
        @(negedge HCLK); bus.s_data = w[1];
        #1 chk("t6_haddr1", bus.HADDR, 20'h00000);
        @(negedge HCLK); bus.s_valid = 1'b0;
        @(negedge HCLK); #1 chk("t6_done", done, 1'b1);
        @(negedge HCLK);

        // Unaligned base is forced to a word boundary
        start = 1'b1; base = 20'h00103; len = 16'd1;
        bus.s_valid = 1'b1; bus.s_data = w[2];
        @(negedge HCLK); start = 1'b0;
        #1 chk("t7_haddr", bus.HADDR, 20'h00100);
        @(negedge HCLK); bus.s_valid = 1'b0;
        @(negedge HCLK); #1 chk("t7_done", done, 1'b1);
        @(negedge HCLK);

        // Start while busy is ignored; reset mid-transfer
        start = 1'b1; base = 20'h00400; len = 16'd3;
        @(negedge HCLK);
        start = 1'b1; base = 20'h00800; len = 16'd1;
        #1 chk("t8_no_valid_htrans", bus.HTRANS, 2'b00);
        @(negedge HCLK); start = 1'b0; bus.s_valid = 1'b1; bus.s_data = w[0];
        #1;
        chk("t8_haddr0", bus.HADDR, 20'h00400);
        @(negedge HCLK); bus.s_data = w[1];
        #1;
        chk("t8_haddr1", bus.HADDR, 20'h00404);
        @(negedge HCLK); bus.s_data = w[2];
        #1;
        chk("t8_rem_kept_htrans", bus.HTRANS, 2'b10);
        chk("t8_haddr2", bus.HADDR, 20'h00408);
        HRESET = 1'b1;
        @(negedge HCLK); HRESET = 1'b0;
        #1;
        chk("t8_rst_htrans", bus.HTRANS, 2'b00);
        chk("t8_rst_busy", busy, 1'b0);
        chk("t8_rst_done", done, 1'b0);
        @(negedge HCLK); #1;
        chk("t8_no_done_after_rst", done, 1'b0);
        chk("t8_idle_after_rst", bus.HTRANS, 2'b00);
        bus.s_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
